// File: rtl/zorro_pkg.sv
// Shared definitions for the Zorro II AutoConfig controller.
//   state_e      : controller state encoding
//   *_OFS        : AutoConfig register word offsets (ADDR[6:1])
//   SIZE_CODE    : er_Type board size code (128 KB)
//   CFG_PAGE     : ADDR[23:16] of the $E8xxxx config space
package zorro_pkg;

  typedef enum logic [2:0] {
    StDisabled,
    StWaitCfgin,
    StRespond,
    StConfigured,
    StShutup
  } state_e;

  // Word offsets: $00, $4A, $48, $4C.
  localparam logic [5:0] ER_TYPE = 6'h00;
  localparam logic [5:0] BASE_LO = 6'h25;
  localparam logic [5:0] BASE_HI = 6'h24;
  localparam logic [5:0] SHUTUP  = 6'h26;

  localparam logic [2:0] SIZE_CODE = 3'b010;
  localparam logic [7:0] CFG_PAGE  = 8'hE8;

endpackage

// File: rtl/autoconfig_rom.sv
// Combinational AutoConfig nibble lookup.
//   offset : word offset within the config page (ADDR[6:1])
//   nibble : value to drive on D15:D12
// Every register reads back inverted except $00, $02, $40 and $42.
module autoconfig_rom
  import zorro_pkg::*;
#(
  parameter logic [15:0] MANUF_ID = 16'h0000,
  parameter logic [7:0]  PROD_ID  = 8'h00,
  parameter logic [31:0] SERIAL   = 32'h00000000,
  parameter logic [15:0] DIAG_VEC = 16'h0000
) (
  input  logic [5:0] offset,
  output logic [3:0] nibble
);

  logic [3:0] raw;
  logic       invert;

  always_comb begin
    raw    = 4'h0;
    invert = 1'b1;
    case (offset)
      ER_TYPE: begin
        raw    = 4'hD;  // Zorro II, no memory link, ROM vector valid
        invert = 1'b0;
      end
      6'h01: begin
        raw    = {1'b0, SIZE_CODE};
        invert = 1'b0;
      end
      6'h02: raw = PROD_ID[7:4];
      6'h03: raw = PROD_ID[3:0];
      6'h08: raw = MANUF_ID[15:12];
      6'h09: raw = MANUF_ID[11:8];
      6'h0A: raw = MANUF_ID[7:4];
      6'h0B: raw = MANUF_ID[3:0];
      6'h0C: raw = SERIAL[31:28];
      6'h0D: raw = SERIAL[27:24];
      6'h0E: raw = SERIAL[23:20];
      6'h0F: raw = SERIAL[19:16];
      6'h10: raw = SERIAL[15:12];
      6'h11: raw = SERIAL[11:8];
      6'h12: raw = SERIAL[7:4];
      6'h13: raw = SERIAL[3:0];
      6'h14: raw = DIAG_VEC[15:12];
      6'h15: raw = DIAG_VEC[11:8];
      6'h16: raw = DIAG_VEC[7:4];
      6'h17: raw = DIAG_VEC[3:0];
      6'h20, 6'h21: invert = 1'b0;
      // Unlisted offsets: inverted zero reads as 4'hF.
      default: raw = 4'h0;
    endcase
  end

  assign nibble = invert ? ~raw : raw;

endmodule

// File: rtl/zorro_autoconfig.sv
// Zorro II AutoConfig controller for the IDE card.
//   CLK, RESET_n          : clock, async active-low reset
//   ADDR[23:1], AS_n,
//   UDS_n, RW, DIN        : CPU bus
//   CFGIN_n / CFGOUT_n    : config chain in / out
//   autoconfig_en         : jumper, low keeps the card transparent
//   DOUT, DOE             : D15:D12 read data and driver enable
//   ide_access            : cycle hits the assigned 128 KB window
//   configured            : base address assigned
module zorro_autoconfig
  import zorro_pkg::*;
#(
  parameter logic [15:0] MANUF_ID = 16'h0000,
  parameter logic [7:0]  PROD_ID  = 8'h00,
  parameter logic [31:0] SERIAL   = 32'h00000000,
  parameter logic [15:0] DIAG_VEC = 16'h0000
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic [23:1] ADDR,
  input  logic        AS_n,
  input  logic        UDS_n,
  input  logic        RW,
  input  logic [3:0]  DIN,
  input  logic        CFGIN_n,
  input  logic        autoconfig_en,
  output logic        CFGOUT_n,
  output logic [3:0]  DOUT,
  output logic        DOE,
  output logic        ide_access,
  output logic        configured
);

  state_e     state_q, state_d;
  logic [7:0] base_q, base_d;
  logic       wr_done_q, wr_done_d;

  logic       cfg_space;
  logic       read_hit;
  logic       wr_hit;
  logic [3:0] rom_nibble;
  logic       unused_bits;

  assign unused_bits = ^{ADDR[15:7], base_q[0]};

  autoconfig_rom #(
    .MANUF_ID (MANUF_ID),
    .PROD_ID  (PROD_ID),
    .SERIAL   (SERIAL),
    .DIAG_VEC (DIAG_VEC)
  ) u_rom (
    .offset (ADDR[6:1]),
    .nibble (rom_nibble)
  );

  assign cfg_space = (ADDR[23:16] == CFG_PAGE);
  assign read_hit  = (state_q == StRespond) && !AS_n && RW && cfg_space;
  // wr_done limits capture to one per AS_n cycle.
  assign wr_hit    = (state_q == StRespond) && !AS_n && !UDS_n && !RW && cfg_space && !wr_done_q;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    wr_done_d = wr_done_q;

    if (AS_n) begin
      wr_done_d = 1'b0;
    end else if (wr_hit) begin
      wr_done_d = 1'b1;
    end

    if (wr_hit) begin
      if (ADDR[6:1] == BASE_LO) base_d[3:0] = DIN;
      if (ADDR[6:1] == BASE_HI) base_d[7:4] = DIN;
    end

    case (state_q)
      StWaitCfgin: begin
        if (!CFGIN_n) state_d = autoconfig_en ? StRespond : StDisabled;
      end
      StRespond: begin
        if (CFGIN_n) begin
          state_d = StWaitCfgin;
        end else if (wr_hit) begin
          if (ADDR[6:1] == BASE_HI) state_d = StConfigured;
          if (ADDR[6:1] == SHUTUP)  state_d = StShutup;
        end
      end
      default: state_d = state_q;  // terminal states hold until reset
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= StWaitCfgin;
      base_q    <= 8'h00;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      wr_done_q <= wr_done_d;
    end
  end

  assign DOE        = read_hit;
  assign DOUT       = read_hit ? rom_nibble : 4'h0;
  assign configured = (state_q == StConfigured);
  assign CFGOUT_n   = !((state_q == StDisabled) || (state_q == StConfigured) ||
                        (state_q == StShutup));
  // wr_done masks the tail of the $48 write cycle, which lands in CONFIGURED.
  assign ide_access = configured && !AS_n && !wr_done_q && (ADDR[23:17] == base_q[7:1]);

endmodule

// File: tb/tb_zorro_autoconfig.sv
// Self-checking bench for zorro_autoconfig: table-driven config reads plus
// hand-written sequences for configuration, shut-up, disable, re-scan and reset.
module tb_zorro_autoconfig;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic [23:1] ADDR;
  logic        AS_n, UDS_n, RW;
  logic [3:0]  DIN;
  logic        CFGIN_n, autoconfig_en;
  logic        CFGOUT_n, DOE, ide_access, configured;
  logic [3:0]  DOUT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  zorro_autoconfig #(
    .MANUF_ID (16'h1234),
    .PROD_ID  (8'h5A),
    .SERIAL   (32'hCAFEBABE),
    .DIAG_VEC (16'h8421)
  ) dut (
    .CLK           (CLK),
    .RESET_n       (RESET_n),
    .ADDR          (ADDR),
    .AS_n          (AS_n),
    .UDS_n         (UDS_n),
    .RW            (RW),
    .DIN           (DIN),
    .CFGIN_n       (CFGIN_n),
    .autoconfig_en (autoconfig_en),
    .CFGOUT_n      (CFGOUT_n),
    .DOUT          (DOUT),
    .DOE           (DOE),
    .ide_access    (ide_access),
    .configured    (configured)
  );

  typedef struct {
    logic [23:0] addr;
    logic        doe;
    logic [3:0]  dout;
  } rd_vec_t;

  rd_vec_t vecs[16];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET_n = 1'b0;
    AS_n = 1'b1; UDS_n = 1'b1; RW = 1'b1; DIN = 4'h0; ADDR = '0;
    CFGIN_n = 1'b1; autoconfig_en = 1'b1;
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;
  endtask

  task automatic enter_respond();
    @(negedge CLK);
    CFGIN_n = 1'b0;
    @(negedge CLK);
  endtask

  // Starts a read half a clock before a rising edge; outputs settle by return.
  task automatic rd_begin(input logic [23:0] a);
    @(negedge CLK);
    ADDR = a[23:1]; RW = 1'b1; AS_n = 1'b0; UDS_n = 1'b0;
    #2;
  endtask

  task automatic wr_begin(input logic [23:0] a, input logic [3:0] d);
    @(negedge CLK);
    ADDR = a[23:1]; DIN = d; RW = 1'b0; AS_n = 1'b0; UDS_n = 1'b0;
  endtask

  task automatic bus_end();
    @(negedge CLK);
    AS_n = 1'b1; UDS_n = 1'b1; RW = 1'b1;
  endtask

  task automatic wr_full(input logic [23:0] a, input logic [3:0] d);
    wr_begin(a, d);
    @(posedge CLK);
    #1;
    bus_end();
  endtask

  task automatic probe(input string name, input logic [23:0] a, input logic exp_ide,
                       input logic exp_doe);
    rd_begin(a);
    check({name, " ide"}, {7'b0, ide_access}, {7'b0, exp_ide});
    check({name, " doe"}, {7'b0, DOE}, {7'b0, exp_doe});
    bus_end();
  endtask

  initial begin
    vecs[0]  = '{24'hE80000, 1'b1, 4'hD};
    vecs[1]  = '{24'hE80002, 1'b1, 4'h2};
    vecs[2]  = '{24'hE80004, 1'b1, 4'hA};
    vecs[3]  = '{24'hE80006, 1'b1, 4'h5};
    vecs[4]  = '{24'hE80010, 1'b1, 4'hE};
    vecs[5]  = '{24'hE80016, 1'b1, 4'hB};
    vecs[6]  = '{24'hE80018, 1'b1, 4'h3};
    vecs[7]  = '{24'hE80026, 1'b1, 4'h1};
    vecs[8]  = '{24'hE8002A, 1'b1, 4'hB};
    vecs[9]  = '{24'hE80040, 1'b1, 4'h0};
    vecs[10] = '{24'hE80042, 1'b1, 4'h0};
    vecs[11] = '{24'hE80044, 1'b1, 4'hF};
    vecs[12] = '{24'hE8007E, 1'b1, 4'hF};
    vecs[13] = '{24'hE80008, 1'b1, 4'hF};
    vecs[14] = '{24'hE90000, 1'b0, 4'h0};
    vecs[15] = '{24'hE8002E, 1'b1, 4'hE};

    // Reset state and idle chain.
    do_reset();
    #1;
    check("rst cfgout", {7'b0, CFGOUT_n}, 8'd1);
    check("rst doe", {7'b0, DOE}, 8'd0);
    check("rst dout", {4'b0, DOUT}, 8'd0);
    check("rst configured", {7'b0, configured}, 8'd0);
    check("rst ide", {7'b0, ide_access}, 8'd0);
    rd_begin(24'hE80000);
    check("wait read doe", {7'b0, DOE}, 8'd0);
    bus_end();
    check("wait cfgout", {7'b0, CFGOUT_n}, 8'd1);

    // Config reads.
    enter_respond();
    for (int i = 0; i < 16; i++) begin
      rd_begin(vecs[i].addr);
      check($sformatf("rd %h doe", vecs[i].addr), {7'b0, DOE}, {7'b0, vecs[i].doe});
      check($sformatf("rd %h dout", vecs[i].addr), {4'b0, DOUT}, {4'b0, vecs[i].dout});
      bus_end();
    end

    // $4A with a UDS_n glitch: second strobe in the same AS_n cycle must be ignored.
    wr_begin(24'hE8004A, 4'h2);
    @(posedge CLK);
    @(negedge CLK);
    UDS_n = 1'b1; DIN = 4'h4;
    @(negedge CLK);
    UDS_n = 1'b0;
    @(posedge CLK);
    #1;
    check("base_lo configured", {7'b0, configured}, 8'd0);
    check("base_lo cfgout", {7'b0, CFGOUT_n}, 8'd1);
    bus_end();

    // $48 completes configuration; its own cycle never hits the window.
    wr_begin(24'hE80048, 4'hE);
    @(posedge CLK);
    #1;
    check("w48 configured", {7'b0, configured}, 8'd1);
    check("w48 cfgout", {7'b0, CFGOUT_n}, 8'd0);
    check("w48 own ide", {7'b0, ide_access}, 8'd0);
    bus_end();
    probe("cfg E20000", 24'hE20000, 1'b1, 1'b0);
    probe("cfg E3FFFE", 24'hE3FFFE, 1'b1, 1'b0);
    probe("cfg E40000", 24'hE40000, 1'b0, 1'b0);
    probe("cfg E80000", 24'hE80000, 1'b0, 1'b0);
    ADDR = 24'hE20000 >> 1;
    #1;
    check("cfg as idle ide", {7'b0, ide_access}, 8'd0);

    // Shut-up.
    do_reset();
    enter_respond();
    wr_full(24'hE8004C, 4'h0);
    #1;
    check("shutup cfgout", {7'b0, CFGOUT_n}, 8'd0);
    check("shutup configured", {7'b0, configured}, 8'd0);
    probe("shutup E80000", 24'hE80000, 1'b0, 1'b0);
    probe("shutup E00000", 24'hE00000, 1'b0, 1'b0);
    probe("shutup E20000", 24'hE20000, 1'b0, 1'b0);

    // Hardware disable.
    do_reset();
    autoconfig_en = 1'b0;
    @(negedge CLK);
    CFGIN_n = 1'b0;
    #1;
    check("dis before edge cfgout", {7'b0, CFGOUT_n}, 8'd1);
    @(posedge CLK);
    #1;
    check("dis cfgout", {7'b0, CFGOUT_n}, 8'd0);
    probe("dis E80000", 24'hE80000, 1'b0, 1'b0);
    probe("dis E80002", 24'hE80002, 1'b0, 1'b0);

    // CFGIN_n rising mid-read drops DOE at the next edge; lowering it re-scans.
    do_reset();
    enter_respond();
    rd_begin(24'hE80000);
    check("rescan doe on", {7'b0, DOE}, 8'd1);
    CFGIN_n = 1'b1;
    #1;
    check("rescan doe held", {7'b0, DOE}, 8'd1);
    @(posedge CLK);
    #1;
    check("rescan doe off", {7'b0, DOE}, 8'd0);
    @(negedge CLK);
    CFGIN_n = 1'b0;
    @(posedge CLK);
    #1;
    check("rescan doe back", {7'b0, DOE}, 8'd1);
    check("rescan dout", {4'b0, DOUT}, 8'hD);
    bus_end();

    // Reset during a $48 write after $4A was captured.
    wr_full(24'hE8004A, 4'h2);
    wr_begin(24'hE80048, 4'hE);
    #1;
    RESET_n = 1'b0;
    #1;
    check("midrst cfgout", {7'b0, CFGOUT_n}, 8'd1);
    check("midrst configured", {7'b0, configured}, 8'd0);
    bus_end();
    @(negedge CLK);
    CFGIN_n = 1'b1;
    RESET_n = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst after cfgout", {7'b0, CFGOUT_n}, 8'd1);
    probe("midrst wait doe", 24'hE80000, 1'b0, 1'b0);
    // Base cleared: configuring with only $48 gives window $E00000.
    enter_respond();
    wr_full(24'hE80048, 4'hE);
    probe("midrst E00000", 24'hE00000, 1'b1, 1'b0);
    probe("midrst E20000", 24'hE20000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
